// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Owner encoding, fetch word size and starvation counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

  localparam logic [2:0] FUNCT3_LW = 3'b010;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (I) and load/store (D).
// D has priority; a starvation counter forces fetch through.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  input  logic        i_flush,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_write_mem,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data
);

  localparam logic [STARVE_W-1:0] LIM =
    STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;
  owner_t              owner;
  owner_t              owner_nxt;
  logic                i_flush_q;
  logic [31:0]         rd_addr_q;
  logic [31:0]         wr_addr_q;
  logic [31:0]         wr_data_q;
  logic [2:0]          f3_q;

  assign starved = (starve_cnt == LIM);

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (i_req && (!d_req || starved))
        i_gnt = 1'b1;
      else if (d_req)
        d_gnt = 1'b1;
    end
  end

  // Ungranted cycles keep the last driven address/data/size.
  always_comb begin
    mem_read_address  = rd_addr_q;
    mem_write_address = wr_addr_q;
    mem_write_data    = wr_data_q;
    mem_funct3        = f3_q;
    mem_write_mem     = 1'b0;
    unique case (1'b1)
      i_gnt: begin
        mem_read_address = i_addr;
        mem_funct3       = FUNCT3_LW;
      end
      d_gnt && d_we: begin
        mem_write_address = d_addr;
        mem_write_data    = d_wdata;
        mem_funct3        = d_funct3;
        mem_write_mem     = 1'b1;
      end
      d_gnt && !d_we: begin
        mem_read_address = d_addr;
        mem_funct3       = d_funct3;
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    if (i_gnt)
      owner_nxt = OWN_I;
    else if (d_gnt && !d_we)
      owner_nxt = OWN_D;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= OWN_NONE;
      starve_cnt <= '0;
      i_flush_q  <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      f3_q       <= '0;
    end else begin
      owner     <= owner_nxt;
      i_flush_q <= i_flush;
      rd_addr_q <= mem_read_address;
      wr_addr_q <= mem_write_address;
      wr_data_q <= mem_write_data;
      f3_q      <= mem_funct3;
      if (i_gnt)
        starve_cnt <= '0;
      else if (i_req && !starved)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Reset in the response cycle drops the pending response.
  assign i_rvalid = (owner == OWN_I) && !i_flush_q &&
                    !i_flush && !reset;
  assign d_rvalid = (owner == OWN_D) && !reset;
  assign i_rdata  = mem_read_data;
  assign d_rdata  = mem_read_data;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single port of the byte-lane `memory` block between the instruction-fetch unit (I port, word reads only) and the load/store unit (D port, reads and writes with `funct3` sizing). Each cycle it grants at most one requester and drives the memory's address, write and `funct3` inputs from the winner. One cycle later it routes the memory's registered `read_data` back to the requester that issued the read. Data accesses have fixed priority, and a starvation counter guarantees forward progress for fetch. The block sits between the core's pipeline front-end/LSU and `memory`.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive denied fetch cycles after which fetch wins the next contested cycle; legal range 1–15.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `i_req` input 1: fetch request; held with `i_addr` stable until `i_gnt`.
- `i_addr` input 32: fetch byte address, word-aligned.
- `i_gnt` output 1: fetch accepted this cycle.
- `i_flush` input 1: discard any fetch response due next cycle.
- `i_rvalid` output 1: fetch data valid.
- `i_rdata` output 32: fetch data.
- `d_req` input 1: data request; held with the fields below until `d_gnt`.
- `d_we` input 1: 1 = store, 0 = load.
- `d_funct3` input 3: RISC-V size/sign encoding.
- `d_addr` input 32: data byte address.
- `d_wdata` input 32: store data, right-aligned.
- `d_gnt` output 1: data request accepted this cycle.
- `d_rvalid` output 1: load data valid.
- `d_rdata` output 32: load data, already sized and extended by `memory`.
- `mem_write_mem` output 1: to `memory.write_mem`.
- `mem_funct3` output 3: to `memory.funct3`.
- `mem_write_address` output 32: to `memory.write_address`.
- `mem_write_data` output 32: to `memory.write_data`.
- `mem_read_address` output 32: to `memory.read_address`.
- `mem_read_data` input 32: from `memory.read_data`.

## Operation
Arbitration is combinational each cycle:
- While `reset` = 1, no grant is issued.
- Only `d_req`: D wins.
- Only `i_req`: I wins.
- Both asserted: D wins, unless `starve_cnt == STARVE_LIMIT`, in which case I wins.

`starve_cnt` is 4 bits:
- Increments on any cycle with `i_req && !i_gnt`, saturating at `STARVE_LIMIT`.
- Clears on `i_gnt`.
- Holds when `i_req` = 0.

Memory drive for the winner:
- I granted: `mem_read_address = i_addr`, `mem_funct3 = 3'b010`, `mem_write_mem = 0`.
- D granted, load: `mem_read_address = d_addr`, `mem_funct3 = d_funct3`, `mem_write_mem = 0`.
- D granted, store: `mem_write_address = d_addr`, `mem_write_data = d_wdata`, `mem_funct3 = d_funct3`, `mem_write_mem = 1`.
- No grant: `mem_write_mem = 0`; addresses and `funct3` hold the last driven values (don't-care).

Response owner register `owner` ∈ {NONE, I, D}:
- Next value is I on an I grant, D on a D load grant, NONE otherwise (including store grants).
- `i_rvalid = (owner == I) && !i_flush_q`, where `i_flush_q` is `i_flush` registered.
- Also, `i_flush` asserted in the grant cycle or the following cycle suppresses that fetch response. `i_rvalid` is combinational on `i_flush` in the response cycle.
- `d_rvalid = (owner == D)`.
- `i_rdata = d_rdata = mem_read_data`; the data is meaningful only while the matching `rvalid` is high.

Address decoding, MMIO behaviour and alignment are owned by `memory`. The arbiter passes addresses through unmodified.

## Timing
- Grant cycle N: request accepted; memory inputs are driven in N.
- Stores commit at the N→N+1 edge. No response is returned for a store.
- Load/fetch data: `rvalid` is high in cycle N+1 only (latency 1).
- Throughput is one grant per cycle. Back-to-back grants to the same or alternating ports are allowed. A grant in N+1 overlaps the response of N.
- A requester must not drop `req` or change its fields before `gnt`.
- Reset values:
  - `owner` = NONE, `starve_cnt` = 0.
  - `i_gnt`, `d_gnt`, `i_rvalid`, `d_rvalid`, `mem_write_mem` are all 0.
  - Address, data and `funct3` outputs are 0.
- Reset asserted in cycle N+1, after a grant in N: the response is dropped and `rvalid` stays 0. A store granted in N has already committed.
- With `STARVE_LIMIT` = L and continuous `d_req`, fetch is granted at least once every L+1 cycles.

## Structure
- Package `mem_arb_pkg` holds:
  - the owner enum `owner_t` {OWN_NONE, OWN_I, OWN_D};
  - `FUNCT3_LW = 3'b010`;
  - the `starve_cnt` width constant.
- Single module `mem_port_arbiter`; no sub-modules are needed.
- Test benches instantiate it together with the real `memory`.

## Test plan
- Fetch only: `i_req` at 0x0, 0x4, 0x8 in consecutive cycles → `i_gnt` high on each cycle; `i_rvalid` high one cycle later each time, with words from the init file.
- Store then load: store word 0xDEADBEEF to 0x100, then load byte unsigned (`funct3` = 3'b100) from 0x101 → `d_rvalid` with `d_rdata` = 0x000000BE two cycles after the store grant.
- Contention, `STARVE_LIMIT` = 4, `d_req` and `i_req` held continuously → D granted on cycles 0–3, I on cycle 4, D on cycles 5–8, I on cycle 9.
- Flush: I granted in N with `i_flush` = 1 in N+1 → `i_rvalid` = 0 in N+1; a concurrent D grant in N+1 yields `d_rvalid` in N+2 as normal.
- Reset mid-transfer: D load granted in N, `reset` asserted in N+1 → `d_rvalid` = 0 in N+1 and N+2; `starve_cnt` = 0; first grant after reset is well-formed.
- MMIO passthrough: store word 0xFF000000 to 0xFFFFFFFC → `mem_write_mem` = 1 with `mem_write_address` = 0xFFFFFFFC; a subsequent load word from the same address returns 0xFF000000.
